interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer.sv | 151 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer.
//
// Accepts an interrupt request from the controller at an instruction boundary,
// acknowledges it, saves the resume PC, redirects the CPU to the vector for the
// latched interrupt index, waits in the service routine until return-from-interrupt,
// then restores the saved PC and signals completion. No nesting.
//
// Ports:
//   clk_i               clock, all state on rising edge
//   rst_ni              asynchronous active-low reset
//   int_req_i           interrupt request level
//   int_number_i        requested interrupt index (valid with int_req_i)
//   int_pending_i       controller has further interrupts queued
//   instr_boundary_i    CPU is between instructions
//   reti_i              return-from-interrupt pulse
//   pc_in_i             address of next instruction to resume
//   int_ack_attended_o  one-cycle pulse: request accepted
//   int_ack_complete_o  one-cycle pulse: service routine finished
//   stall_o             freeze CPU fetch/execute
//   load_pc_o           one-cycle pulse: CPU loads pc_out_o
//   pc_out_o            target PC, zero when load_pc_o is low
//   in_isr_o            service routine active
//   active_number_o     index of interrupt being serviced
//   chain_hint_o        int_pending_i captured at acceptance
module interrupt_sequencer #(
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0010,
  parameter int unsigned VECTOR_STRIDE = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        int_req_i,
  input  logic [1:0]  int_number_i,
  input  logic        int_pending_i,
  input  logic        instr_boundary_i,
  input  logic        reti_i,
  input  logic [31:0] pc_in_i,
  output logic        int_ack_attended_o,
  output logic        int_ack_complete_o,
  output logic        stall_o,
  output logic        load_pc_o,
  output logic [31:0] pc_out_o,
  output logic        in_isr_o,
  output logic [1:0]  active_number_o,
  output logic        chain_hint_o
);

  typedef enum logic [2:0] {
    StIdle,
    StAck,
    StSave,
    StJump,
    StIsr,
    StRet
  } state_e;

  localparam logic [31:0] Stride = 32'(VECTOR_STRIDE);

  state_e      state_q, state_d;
  logic [1:0]  active_number_q, active_number_d;
  logic        chain_hint_q, chain_hint_d;
  logic [31:0] saved_pc_q, saved_pc_d;

  logic        accept;
  logic        stall_raw;
  logic [31:0] vector_addr;

  assign accept = int_req_i & instr_boundary_i;

  // Vector arithmetic is 32-bit and wraps modulo 2^32.
  assign vector_addr = VECTOR_BASE + ({30'd0, active_number_q} * Stride);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      active_number_q <= 2'd0;
      chain_hint_q    <= 1'b0;
      saved_pc_q      <= 32'd0;
    end else begin
      state_q         <= state_d;
      active_number_q <= active_number_d;
      chain_hint_q    <= chain_hint_d;
      saved_pc_q      <= saved_pc_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    active_number_d    = active_number_q;
    chain_hint_d       = chain_hint_q;
    saved_pc_d         = saved_pc_q;
    int_ack_attended_o = 1'b0;
    int_ack_complete_o = 1'b0;
    stall_raw          = 1'b0;
    load_pc_o          = 1'b0;
    pc_out_o           = 32'd0;
    in_isr_o           = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Freeze the CPU in the same cycle the request is seen so it cannot
        // start another instruction before the acknowledge.
        stall_raw = accept;
        if (accept) begin
          state_d         = StAck;
          active_number_d = int_number_i;
          chain_hint_d    = int_pending_i;
        end
      end
      StAck: begin
        int_ack_attended_o = 1'b1;
        stall_raw          = 1'b1;
        state_d            = StSave;
      end
      StSave: begin
        stall_raw  = 1'b1;
        saved_pc_d = pc_in_i;
        state_d    = StJump;
      end
      StJump: begin
        stall_raw = 1'b1;
        load_pc_o = 1'b1;
        pc_out_o  = vector_addr;
        state_d   = StIsr;
      end
      StIsr: begin
        // New requests are ignored here: no nesting.
        in_isr_o = 1'b1;
        if (reti_i) begin
          state_d = StRet;
        end
      end
      StRet: begin
        stall_raw          = 1'b1;
        load_pc_o          = 1'b1;
        pc_out_o           = saved_pc_q;
        int_ack_complete_o = 1'b1;
        // Always pass through IDLE before a new entry.
        state_d            = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The IDLE stall term depends on live inputs; mask it while reset is held.
  assign stall_o         = stall_raw & rst_ni;
  assign active_number_o = active_number_q;
  assign chain_hint_o    = chain_hint_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, bnd, pend, reti;
  logic [1:0]  num;
  logic [31:0] pc;

  logic        att, cmp, stall, load, isr, chain;
  logic [1:0]  anum;
  logic [31:0] pco;
  logic        w_att, w_cmp, w_stall, w_load, w_isr, w_chain;
  logic [1:0]  w_anum;
  logic [31:0] w_pco;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .int_req_i          (req),
    .int_number_i       (num),
    .int_pending_i      (pend),
    .instr_boundary_i   (bnd),
    .reti_i             (reti),
    .pc_in_i            (pc),
    .int_ack_attended_o (att),
    .int_ack_complete_o (cmp),
    .stall_o            (stall),
    .load_pc_o          (load),
    .pc_out_o           (pco),
    .in_isr_o           (isr),
    .active_number_o    (anum),
    .chain_hint_o       (chain)
  );

  // Second instance exercises vector address wrap-around.
  interrupt_sequencer #(
    .VECTOR_BASE   (32'hFFFF_FFFC),
    .VECTOR_STRIDE (4)
  ) dut_wrap (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .int_req_i          (req),
    .int_number_i       (num),
    .int_pending_i      (pend),
    .instr_boundary_i   (bnd),
    .reti_i             (reti),
    .pc_in_i            (pc),
    .int_ack_attended_o (w_att),
    .int_ack_complete_o (w_cmp),
    .stall_o            (w_stall),
    .load_pc_o          (w_load),
    .pc_out_o           (w_pco),
    .in_isr_o           (w_isr),
    .active_number_o    (w_anum),
    .chain_hint_o       (w_chain)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: tracks a service in terms of cycles elapsed since acceptance.
  bit          m_busy;
  int          m_since;     // cycles since acceptance edge (1 = acknowledge cycle)
  bit          m_returning;
  logic [1:0]  m_num;
  logic        m_pend;
  logic [31:0] m_saved;

  logic        e_att, e_cmp, e_stall, e_load, e_isr;
  logic [31:0] e_pc, e_pcw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy      = 1'b0;
    m_since     = 0;
    m_returning = 1'b0;
    m_num       = 2'd0;
    m_pend      = 1'b0;
    m_saved     = 32'd0;
  endtask

  task automatic compute_expected();
    e_att = 0; e_cmp = 0; e_stall = 0; e_load = 0; e_isr = 0;
    e_pc  = 32'd0; e_pcw = 32'd0;
    if (rst_n !== 1'b1) begin
      // everything quiet while in reset
    end else if (!m_busy) begin
      e_stall = req & bnd;
    end else if (m_returning) begin
      e_stall = 1; e_load = 1; e_cmp = 1;
      e_pc = m_saved; e_pcw = m_saved;
    end else if (m_since == 1) begin
      e_att = 1; e_stall = 1;
    end else if (m_since == 2) begin
      e_stall = 1;
    end else if (m_since == 3) begin
      e_stall = 1; e_load = 1;
      e_pc  = 32'h0000_0010 + 32'(m_num) * 32'd4;
      e_pcw = 32'hFFFF_FFFC + 32'(m_num) * 32'd4;
    end else begin
      e_isr = 1;
    end
  endtask

  task automatic check_outputs();
    compute_expected();
    chk("attended", {31'd0, att}, {31'd0, e_att});
    chk("complete", {31'd0, cmp}, {31'd0, e_cmp});
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("load_pc", {31'd0, load}, {31'd0, e_load});
    chk("pc_out", pco, e_pc);
    chk("in_isr", {31'd0, isr}, {31'd0, e_isr});
    chk("active_number", {30'd0, anum}, {30'd0, m_num});
    chk("chain_hint", {31'd0, chain}, {31'd0, m_pend});
    chk("wrap_pc_out", w_pco, e_pcw);
    chk("wrap_load_pc", {31'd0, w_load}, {31'd0, e_load});
  endtask

  task automatic model_edge();
    if (rst_n !== 1'b1) begin
      model_reset();
    end else if (!m_busy) begin
      if (req && bnd) begin
        m_busy      = 1'b1;
        m_since     = 1;
        m_returning = 1'b0;
        m_num       = num;
        m_pend      = pend;
      end
    end else if (m_returning) begin
      m_busy      = 1'b0;
      m_returning = 1'b0;
    end else begin
      if (m_since == 2) m_saved = pc;
      if (m_since >= 4 && reti) m_returning = 1'b1;
      else if (m_since < 4) m_since = m_since + 1;
    end
  endtask

  // One clock cycle: drive at falling edge, check, then advance the model at the rising edge.
  task automatic cycle(input logic r, input logic q, input logic b, input logic [1:0] n,
                       input logic p, input logic t, input logic [31:0] a);
    @(negedge clk);
    rst_n = r; req = q; bnd = b; num = n; pend = p; reti = t; pc = a;
    if (!r) model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  // Reset dropped between clock edges: outputs must clear before the next edge.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0; req = 0; bnd = 0; num = 0; pend = 0; reti = 0; pc = 0;

    // Reset with an active request present: nothing may happen.
    cycle(0, 1, 1, 2'd3, 1, 1, 32'h55);
    cycle(0, 1, 1, 2'd3, 1, 0, 32'h55);
    cycle(1, 0, 0, 2'd0, 0, 0, 32'h0);

    // Basic service: number 2, resume at 0x100, vector 0x18.
    cycle(1, 1, 1, 2'd2, 0, 0, 32'h100);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 2'd0, 0, 0, 32'h100);
    cycle(1, 0, 0, 2'd0, 0, 1, 32'h100);
    cycle(1, 0, 0, 2'd0, 0, 0, 32'h104);
    cycle(1, 0, 0, 2'd0, 0, 0, 32'h104);

    // Request without boundary: no entry and no stall; boundary then admits it.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 2'd0, 0, 0, 32'h200);
    cycle(1, 1, 1, 2'd0, 0, 0, 32'h200);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 2'd0, 0, 0, 32'h200);
    cycle(1, 0, 0, 2'd0, 0, 1, 32'h200);
    cycle(1, 0, 0, 2'd0, 0, 0, 32'h204);

    // Back-to-back with request held high: numbers 1 then 3, pending flag set.
    cycle(1, 1, 1, 2'd1, 1, 0, 32'h300);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 2'd3, 1, 0, 32'h300);
    cycle(1, 1, 1, 2'd3, 1, 1, 32'h300);
    for (int i = 0; i < 6; i++) cycle(1, 1, 1, 2'd3, 1, 0, 32'h400);
    cycle(1, 0, 1, 2'd0, 0, 1, 32'h400);
    cycle(1, 0, 1, 2'd0, 0, 0, 32'h404);

    // Stray reti in IDLE, then request drops and index changes during ACK.
    cycle(1, 0, 1, 2'd0, 0, 1, 32'h500);
    cycle(1, 0, 1, 2'd0, 0, 0, 32'h500);
    cycle(1, 1, 1, 2'd2, 0, 0, 32'h500);
    cycle(1, 0, 1, 2'd1, 1, 0, 32'h500);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 2'd1, 1, 0, 32'h500);
    cycle(1, 0, 1, 2'd0, 0, 1, 32'h500);
    cycle(1, 0, 1, 2'd0, 0, 0, 32'h504);

    // Asynchronous reset in the middle of ISR, then re-entry with number 1.
    cycle(1, 1, 1, 2'd3, 1, 0, 32'h600);
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 2'd0, 0, 0, 32'h600);
    mid_reset();
    @(posedge clk);
    model_edge();
    cycle(0, 0, 1, 2'd0, 0, 1, 32'h600);
    cycle(1, 0, 1, 2'd0, 0, 1, 32'h600);
    cycle(1, 1, 1, 2'd1, 0, 0, 32'h700);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 2'd0, 0, 0, 32'h700);
    cycle(1, 0, 1, 2'd0, 0, 1, 32'h700);
    cycle(1, 0, 1, 2'd0, 0, 0, 32'h704);

    // Randomized traffic, including rare reset cycles.
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 49) != 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 9) < 2), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
